// File: rtl/pic_pkg.sv
// Shared constants and helpers for the interrupt request front end.
//   NUM_IRQ      number of request lines (fixed at 8)
//   IRQ_IDW      width of a request index
//   SPURIOUS_ID  id reported when an acknowledge finds no pending winner
//   LOWEST_RST   reset value of the priority pointer (IR0 highest)
//   onehot_to_idx()  one-hot vector to binary index
package pic_pkg;

   localparam int unsigned NUM_IRQ = 8;
   localparam int unsigned IRQ_IDW = 3;

   localparam logic [IRQ_IDW-1:0] SPURIOUS_ID = 3'd7;
   localparam logic [IRQ_IDW-1:0] LOWEST_RST  = 3'd7;

   // Returns the index of the highest set bit; a proper one-hot input has exactly one.
   function automatic logic [IRQ_IDW-1:0] onehot_to_idx(input logic [NUM_IRQ-1:0] oh);
      logic [IRQ_IDW-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (oh[i]) idx = IRQ_IDW'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/pic_prio_scan.sv
// Rotating first-one finder.
// Scans vec starting at lowest+1, wrapping mod 8, and reports the first set bit.
//   vec_i     [7:0]  candidate bits
//   lowest_i  [2:0]  current lowest-priority level
//   onehot_o  [7:0]  first set bit in scan order (0 if none)
//   idx_o     [2:0]  its binary index
//   rank_o    [2:0]  its position in scan order, 0 = highest priority
//   any_o            vec_i is non-zero
module pic_prio_scan
   import pic_pkg::*;
(
   input  logic [NUM_IRQ-1:0] vec_i,
   input  logic [IRQ_IDW-1:0] lowest_i,
   output logic [NUM_IRQ-1:0] onehot_o,
   output logic [IRQ_IDW-1:0] idx_o,
   output logic [IRQ_IDW-1:0] rank_o,
   output logic               any_o
);

   logic [IRQ_IDW-1:0] pos;
   logic               found;

   always_comb begin
      onehot_o = '0;
      rank_o   = '0;
      found    = 1'b0;
      pos      = '0;
      for (int k = 0; k < NUM_IRQ; k++) begin
         // 3-bit sum wraps naturally, giving the mod-8 scan order.
         pos = lowest_i + IRQ_IDW'(k + 1);
         if (!found && vec_i[pos]) begin
            found         = 1'b1;
            onehot_o[pos] = 1'b1;
            rank_o        = IRQ_IDW'(k);
         end
      end
   end

   assign idx_o = onehot_to_idx(onehot_o);
   assign any_o = found;

endmodule

// File: rtl/pic_irq_resolver.sv
// Interrupt request front end for the 8259-style controller.
// Captures IR lines into IRR, applies IMR, resolves priority with a rotatable
// pointer and maintains ISR.
// Build option: PIC_IR_SYNC_EN adds a 2-flop synchroniser on ir_i.
//   clk_i, rst_n_i        clock, async active-low reset
//   ir_i [7:0]            raw request lines
//   ltim_i                1 = level trigger, 0 = edge trigger
//   imr_i [7:0]           mask, 1 masks the line
//   int_ack_i             first-INTA pulse
//   eoi_i                 EOI command pulse
//   eoi_specific_i        1 = specific EOI (eoi_level_i), 0 = non-specific
//   eoi_level_i [2:0]     level cleared by a specific EOI
//   eoi_rotate_i          move the priority pointer to the cleared level
//   irr_o, isr_o [7:0]    request / in-service registers
//   priority_o [7:0]      registered one-hot winning unmasked request
//   int_id_o [2:0]        index of last acknowledged level, 7 if spurious
//   int_req_o             request to raise INT
module pic_irq_resolver
   import pic_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic [NUM_IRQ-1:0] ir_i,
   input  logic               ltim_i,
   input  logic [NUM_IRQ-1:0] imr_i,
   input  logic               int_ack_i,
   input  logic               eoi_i,
   input  logic               eoi_specific_i,
   input  logic [IRQ_IDW-1:0] eoi_level_i,
   input  logic               eoi_rotate_i,
   output logic [NUM_IRQ-1:0] irr_o,
   output logic [NUM_IRQ-1:0] isr_o,
   output logic [NUM_IRQ-1:0] priority_o,
   output logic [IRQ_IDW-1:0] int_id_o,
   output logic               int_req_o
);

   logic [NUM_IRQ-1:0] ir_s;

`ifdef PIC_IR_SYNC_EN
   logic [NUM_IRQ-1:0] sync1_q, sync2_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= ir_i;
         sync2_q <= sync1_q;
      end
   end

   assign ir_s = sync2_q;
`else
   assign ir_s = ir_i;
`endif

   logic [NUM_IRQ-1:0] irr_q, irr_d;
   logic [NUM_IRQ-1:0] isr_q, isr_d;
   logic [NUM_IRQ-1:0] prio_q;
   logic [IRQ_IDW-1:0] prio_idx_q;
   logic [IRQ_IDW-1:0] int_id_q, int_id_d;
   logic               int_req_q, int_req_d;
   logic [IRQ_IDW-1:0] lowest_q, lowest_d;
   logic [NUM_IRQ-1:0] ir_prev_q;

   logic [NUM_IRQ-1:0] cand;
   logic [NUM_IRQ-1:0] win_oh;
   logic [IRQ_IDW-1:0] win_idx, win_rank;
   logic               win_any;
   logic [NUM_IRQ-1:0] top_oh;
   logic [IRQ_IDW-1:0] top_idx, top_rank;
   logic               top_any;

   logic [NUM_IRQ-1:0] ack_set;
   logic [NUM_IRQ-1:0] eoi_clr;
   logic [IRQ_IDW-1:0] eoi_idx;

   assign cand = irr_q & ~imr_i;

   pic_prio_scan u_scan_cand (
      .vec_i    (cand),
      .lowest_i (lowest_q),
      .onehot_o (win_oh),
      .idx_o    (win_idx),
      .rank_o   (win_rank),
      .any_o    (win_any)
   );

   pic_prio_scan u_scan_isr (
      .vec_i    (isr_q),
      .lowest_i (lowest_q),
      .onehot_o (top_oh),
      .idx_o    (top_idx),
      .rank_o   (top_rank),
      .any_o    (top_any)
   );

   // A request is only worth raising if it nests above whatever is in service.
   assign int_req_d = win_any && (!top_any || (win_rank < top_rank));

   // Acknowledge acts on the registered winner, so a withdrawn request is spurious.
   assign ack_set  = int_ack_i ? prio_q : '0;
   assign int_id_d = !int_ack_i     ? int_id_q   :
                     (prio_q != '0) ? prio_idx_q : SPURIOUS_ID;

   always_comb begin
      eoi_clr = '0;
      eoi_idx = top_idx;
      if (eoi_i) begin
         if (eoi_specific_i) begin
            eoi_idx = eoi_level_i;
            eoi_clr = isr_q & (NUM_IRQ'(1) << eoi_level_i);
         end else begin
            // Non-specific EOI picks from the pre-ack ISR.
            eoi_clr = top_oh;
         end
      end
   end

   // Rotation only happens when the EOI actually clears a bit.
   assign lowest_d = (eoi_i && eoi_rotate_i && (eoi_clr != '0)) ? eoi_idx : lowest_q;

   assign isr_d = (isr_q & ~eoi_clr) | ack_set;

   always_comb begin
      if (ltim_i) irr_d = ir_s & ~ack_set;
      else        irr_d = (irr_q | (ir_s & ~ir_prev_q)) & ~ack_set;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         irr_q      <= '0;
         isr_q      <= '0;
         prio_q     <= '0;
         prio_idx_q <= '0;
         int_id_q   <= '0;
         int_req_q  <= 1'b0;
         lowest_q   <= LOWEST_RST;
         ir_prev_q  <= '0;
      end else begin
         irr_q      <= irr_d;
         isr_q      <= isr_d;
         prio_q     <= win_oh;
         prio_idx_q <= win_idx;
         int_id_q   <= int_id_d;
         int_req_q  <= int_req_d;
         lowest_q   <= lowest_d;
         ir_prev_q  <= ir_s;
      end
   end

   assign irr_o      = irr_q;
   assign isr_o      = isr_q;
   assign priority_o = prio_q;
   assign int_id_o   = int_id_q;
   assign int_req_o  = int_req_q;

endmodule

// File: doc/pic_irq_resolver.md
# pic_irq_resolver

Interrupt request front end for the 8259-style controller: captures the eight IR lines into the IRR, applies the IMR, resolves priority with a rotatable priority pointer, and maintains the ISR. It sits directly upstream of the control logic. It feeds that block IRR, ISR, the winning request and INT-request qualification. It consumes the control logic's first-acknowledge pulse and its EOI commands.

## Interface
- `NUM_IRQ`, 8: number of request lines. Fixed at 8; the parameter exists for the package constant only.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ir` in 8: raw interrupt request lines.
- `ltim` in 1: trigger mode. 1 = level, 0 = edge (ICW1 bit 3).
- `imr` in 8: mask register; 1 masks the line.
- `int_ack` in 1: one-cycle pulse from the control logic at the first INTA.
- `eoi` in 1: one-cycle EOI command pulse.
- `eoi_specific` in 1: qualifies `eoi`. 1 = specific, 0 = non-specific.
- `eoi_level` in 3: level to clear for a specific EOI.
- `eoi_rotate` in 1: qualifies `eoi`. Rotates priority to the cleared level.
- `IRR` out 8: interrupt request register.
- `ISR` out 8: in-service register.
- `priority` out 8: one-hot winning unmasked request; 0 if none.
- `int_id` out 3: binary index of the last acknowledged level; 7 on a spurious acknowledge.
- `int_req` out 1: request to raise INT.

## Operation
- Reset values:
  - IRR, ISR, `priority` = 0.
  - `int_id` = 0.
  - `int_req` = 0.
  - Priority pointer `lowest` = 7, so IR0 has the highest priority.
  - Edge-detect history = 0.
- Capture, using the sampled `ir_s` (`ir`, or its synchronised copy):
  - Edge mode: IRR[i] sets on `ir_s[i] & ~ir_prev[i]`. It then stays set until acknowledged.
  - Level mode: IRR[i] <= `ir_s[i]` every cycle.
  - Acknowledged-bit clear overrides set in the ack cycle for both modes. In level mode the bit re-sets the following cycle if IR is still high.
- Resolution, combinational and then registered:
  - Scan order starts at `lowest+1` and wraps mod 8.
  - `cand` = IRR & ~imr.
  - `win` = first `cand` bit in scan order.
  - `top_isr` = first ISR bit in scan order.
  - `int_req` = `cand` is non-zero AND (ISR is 0 OR `win` precedes `top_isr` in scan order).
- Acknowledge (`int_ack`):
  - If registered `priority` is non-zero: ISR |= `priority`, IRR &= ~`priority`, `int_id` = index.
  - If `priority` is 0 (request withdrawn): this is spurious. ISR and IRR are unchanged and `int_id` = 7.
- EOI:
  - Non-specific: clears `top_isr`.
  - Specific: clears ISR[`eoi_level`].
  - With `eoi_rotate`: `lowest` <= cleared level.
  - On an empty ISR, or an already-clear specific bit, the command is a no-op and `lowest` is unchanged.
- Simultaneous events:
  - EOI and ack in the same cycle: ISR_next = (ISR & ~eoi_clr) | ack_set.
  - Non-specific EOI selects its bit from the pre-ack ISR.
  - `priority` and `int_req` use the pre-update pointer that cycle.

## Timing
- IR rise at edge n, no synchroniser:
  - IRR valid after edge n+1.
  - `priority` and `int_req` valid after edge n+2.
- `int_ack` at edge k:
  - ISR and IRR update at edge k.
  - `int_req` re-evaluates at k+1.
- EOI at edge k:
  - ISR and `lowest` update at edge k.
  - A pending lower request raises `int_req` at k+1.
- Mid-operation reset clears everything immediately, regardless of clock.
- IMR changes take effect on `priority` and `int_req` one cycle later.

## Configuration
- `PIC_IR_SYNC_EN` defined: `ir` passes through a 2-flop synchroniser before capture. This adds 2 cycles to IR→IRR latency. Synchroniser flops reset to 0.
- Undefined: `ir` is sampled directly and is assumed synchronous to `clk`.

## Structure
- Package `pic_pkg`:
  - `NUM_IRQ` = 8 and `IRQ_IDW` = 3.
  - `SPURIOUS_ID` = 3'd7.
  - Reset pointer `LOWEST_RST` = 3'd7.
  - Function for one-hot to index conversion.
- Sub-module `pic_prio_scan`: rotating first-one finder with inputs `vec[7:0]` and `lowest[2:0]`, and outputs `onehot[7:0]`, `idx[2:0]`, `rank[2:0]` and `any`. Instantiated twice, once for `cand` and once for ISR.

## Test plan
- Edge mode, `ir` = 0x04 at cycle 2, held: IRR = 0x04 at 3, `priority` = 0x04 and `int_req` = 1 at 4. Ack: ISR = 0x04, IRR = 0, `int_id` = 2. No re-set of IRR while IR is held.
- ISR = 0x04, then IR1 and IR5 are asserted: `priority` = 0x02 and `int_req` = 1, because IR1 nests above IR2. IR5 alone keeps `int_req` = 0 until non-specific EOI clears ISR bit 2.
- Level mode, IR3 is pulsed and dropped before ack: `int_req` falls, and the ack returns `int_id` = 7 with ISR unchanged.
- Rotating EOI on ISR = 0x01: ISR = 0, `lowest` = 0. IR0 and IR1 are then both pending: `priority` = 0x02.
- Specific EOI on level 6 with ISR = 0x41, same cycle as an ack of IR3: ISR = 0x09.
- `imr` = 0xFF with all IR high: IRR follows the inputs, `priority` = 0, `int_req` = 0. `rst_n` low mid-nest clears all state asynchronously.
